// File: rtl/dmem_if.sv
// Load/store request and response channels between an initiator and the data-memory responder.
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed latency, range/alignment checks and an error counter.
//   state | meaning
//   IDLE  | ready to accept a request
//   WAIT  | request captured, latency counter running
//   RESP  | response held until the initiator consumes it
module dmem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic       clk,
  input  logic       reset,
  dmem_if.slave      bus,
  output logic [7:0] err_count
);
  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN     = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  LAT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nx;
  logic [3:0]  lat_cnt, lat_cnt_nx;
  logic        hold_we;
  logic [31:0] hold_addr, hold_wdata;
  logic        cur_we;
  logic [31:0] cur_addr, cur_wdata, offset;
  logic        cur_err;
  logic [AW-1:0] cur_idx;
  logic        enter_resp;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] mem [DEPTH_WORDS];

  // With LATENCY=1 the commit edge is the acceptance edge, so decode the live inputs in IDLE.
  always_comb begin
    cur_we    = (state == IDLE) ? bus.req_we    : hold_we;
    cur_addr  = (state == IDLE) ? bus.req_addr  : hold_addr;
    cur_wdata = (state == IDLE) ? bus.req_wdata : hold_wdata;
    offset    = cur_addr - BASE_ADDR;
    cur_err   = (cur_addr[1:0] != 2'b00) || (offset >= SPAN);
    cur_idx   = offset[AW+1:2];
  end

  always_comb begin
    state_nx   = state;
    lat_cnt_nx = lat_cnt;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (LATENCY == 1) begin
            state_nx = RESP;
          end else begin
            state_nx   = WAIT;
            lat_cnt_nx = LAT_LOAD;
          end
        end
      end
      WAIT: begin
        if (lat_cnt == 4'd0) state_nx = RESP;
        else                 lat_cnt_nx = lat_cnt - 4'd1;
      end
      RESP: begin
        if (bus.resp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    enter_resp = (state != RESP) && (state_nx == RESP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      lat_cnt    <= 4'd0;
      rdata_q    <= 32'd0;
      err_q      <= 1'b0;
      err_count  <= 8'd0;
      hold_we    <= 1'b0;
      hold_addr  <= 32'd0;
      hold_wdata <= 32'd0;
    end else begin
      state   <= state_nx;
      lat_cnt <= lat_cnt_nx;
      if (state == IDLE && bus.req_valid) begin
        hold_we    <= bus.req_we;
        hold_addr  <= bus.req_addr;
        hold_wdata <= bus.req_wdata;
      end
      if (enter_resp) begin
        err_q   <= cur_err;
        rdata_q <= (cur_we || cur_err) ? 32'd0 : mem[cur_idx];
        if (cur_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (!reset && enter_resp && cur_we && !cur_err) mem[cur_idx] <= cur_wdata;
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances (LATENCY 2, 1, 3) share stimulus; one is observed at a time.
module tb_dmem_responder;
  localparam logic [31:0] BASE = 32'h1001_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we, resp_ready;
  logic [31:0] req_addr, req_wdata;
  int          sel;
  int          n_chk = 0;
  int          n_fail = 0;

  logic        s_req_ready, s_resp_valid, s_resp_err;
  logic [31:0] s_resp_rdata;
  logic [7:0]  s_err_count, ec2, ec1, ec3;

  dmem_if b2();
  dmem_if b1();
  dmem_if b3();

  assign b2.req_valid = req_valid;  assign b2.req_we = req_we;  assign b2.req_addr = req_addr;
  assign b2.req_wdata = req_wdata;  assign b2.resp_ready = resp_ready;
  assign b1.req_valid = req_valid;  assign b1.req_we = req_we;  assign b1.req_addr = req_addr;
  assign b1.req_wdata = req_wdata;  assign b1.resp_ready = resp_ready;
  assign b3.req_valid = req_valid;  assign b3.req_we = req_we;  assign b3.req_addr = req_addr;
  assign b3.req_wdata = req_wdata;  assign b3.resp_ready = resp_ready;

  dmem_responder #(.LATENCY(2)) u_l2 (.clk(clk), .reset(reset), .bus(b2), .err_count(ec2));
  dmem_responder #(.LATENCY(1)) u_l1 (.clk(clk), .reset(reset), .bus(b1), .err_count(ec1));
  dmem_responder #(.LATENCY(3)) u_l3 (.clk(clk), .reset(reset), .bus(b3), .err_count(ec3));

  always #5 clk = ~clk;

  always_comb begin
    case (sel)
      1: begin
        s_req_ready = b1.req_ready;  s_resp_valid = b1.resp_valid;
        s_resp_rdata = b1.resp_rdata; s_resp_err = b1.resp_err; s_err_count = ec1;
      end
      2: begin
        s_req_ready = b3.req_ready;  s_resp_valid = b3.resp_valid;
        s_resp_rdata = b3.resp_rdata; s_resp_err = b3.resp_err; s_err_count = ec3;
      end
      default: begin
        s_req_ready = b2.req_ready;  s_resp_valid = b2.resp_valid;
        s_resp_rdata = b2.resp_rdata; s_resp_err = b2.resp_err; s_err_count = ec2;
      end
    endcase
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic [7:0]  ec;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One full transaction; while it is outstanding a bogus store to word 0 is held on the request lines.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err, input logic [7:0] exp_ec,
                      input int lat, input string nm);
    int n;
    @(negedge clk);
    chk({nm, " ready_before"}, {31'd0, s_req_ready}, 32'd1);
    req_we = we; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    req_we = 1'b1; req_addr = BASE; req_wdata = 32'hBAD0_BAD0;
    while (!s_resp_valid && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk({nm, " latency"}, n, lat);
    chk({nm, " rdata"}, s_resp_rdata, exp_rd);
    chk({nm, " err"}, {31'd0, s_resp_err}, {31'd0, exp_err});
    chk({nm, " err_count"}, {24'd0, s_err_count}, {24'd0, exp_ec});
    req_valid = 1'b0; resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    chk({nm, " valid_after"}, {31'd0, s_resp_valid}, 32'd0);
    chk({nm, " ready_after"}, {31'd0, s_req_ready}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic seen;
    vecs[0]  = '{1'b1, 32'h1001_0000, 32'h1111_2222, 32'h0,         1'b0, 8'd0};
    vecs[1]  = '{1'b1, 32'h1001_0008, 32'hCAFE_F00D, 32'h0,         1'b0, 8'd0};
    vecs[2]  = '{1'b0, 32'h1001_0008, 32'h0,         32'hCAFE_F00D, 1'b0, 8'd0};
    vecs[3]  = '{1'b0, 32'h1001_0002, 32'h0,         32'h0,         1'b1, 8'd1};
    vecs[4]  = '{1'b1, 32'h1001_1000, 32'hFFFF_FFFF, 32'h0,         1'b1, 8'd2};
    vecs[5]  = '{1'b0, 32'h1001_0000, 32'h0,         32'h1111_2222, 1'b0, 8'd2};
    vecs[6]  = '{1'b1, 32'h1001_0FFC, 32'h5A5A_5A5A, 32'h0,         1'b0, 8'd2};
    vecs[7]  = '{1'b0, 32'h1001_0FFC, 32'h0,         32'h5A5A_5A5A, 1'b0, 8'd2};
    vecs[8]  = '{1'b0, 32'h1000_FFFC, 32'h0,         32'h0,         1'b1, 8'd3};
    vecs[9]  = '{1'b1, 32'h1001_0FFE, 32'h1234_5678, 32'h0,         1'b1, 8'd4};
    vecs[10] = '{1'b0, 32'h1001_0000, 32'h0,         32'h1111_2222, 1'b0, 8'd4};

    sel = 0; reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; resp_ready = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0;
    do_reset();

    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk($sformatf("rst%0d req_ready", s), {31'd0, s_req_ready}, 32'd1);
      chk($sformatf("rst%0d resp_valid", s), {31'd0, s_resp_valid}, 32'd0);
      chk($sformatf("rst%0d rdata", s), s_resp_rdata, 32'd0);
      chk($sformatf("rst%0d err", s), {31'd0, s_resp_err}, 32'd0);
      chk($sformatf("rst%0d err_count", s), {24'd0, s_err_count}, 32'd0);
    end

    sel = 0;
    for (int i = 0; i < 11; i++)
      xact(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].err, vecs[i].ec, 2,
           $sformatf("vec%0d", i));

    // Back-pressure: five cycles with resp_ready low, handshake in the sixth.
    @(negedge clk);
    req_we = 1'b0; req_addr = 32'h1001_0008; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_we = 1'b1; req_addr = BASE; req_wdata = 32'hBAD0_BAD0;
    n = 0;
    while (!s_resp_valid && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("bp wait", n, 1);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp%0d valid", c), {31'd0, s_resp_valid}, 32'd1);
      chk($sformatf("bp%0d rdata", c), s_resp_rdata, 32'hCAFE_F00D);
      chk($sformatf("bp%0d err", c), {31'd0, s_resp_err}, 32'd0);
      chk($sformatf("bp%0d req_ready", c), {31'd0, s_req_ready}, 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    chk("bp6 valid", {31'd0, s_resp_valid}, 32'd1);
    req_valid = 1'b0; resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    chk("bp7 valid", {31'd0, s_resp_valid}, 32'd0);
    chk("bp7 req_ready", {31'd0, s_req_ready}, 32'd1);
    xact(1'b0, BASE, 32'h0, 32'h1111_2222, 1'b0, 8'd4, 2, "bp word0");

    // Reset while a store is in WAIT (LATENCY=3).
    sel = 2;
    do_reset();
    xact(1'b1, 32'h1001_0010, 32'h0123_4567, 32'h0, 1'b0, 8'd0, 3, "l3 store");
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h1001_0010; req_wdata = 32'h89AB_CDEF; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("l3 in_wait ready", {31'd0, s_req_ready}, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
      if (s_resp_valid) seen = 1'b1;
    end
    chk("l3 no_resp_after_reset", {31'd0, seen}, 32'd0);
    xact(1'b0, 32'h1001_0010, 32'h0, 32'h0123_4567, 1'b0, 8'd0, 3, "l3 load_prior");

    // LATENCY=1 and err_count saturation.
    sel = 1;
    do_reset();
    xact(1'b1, 32'h1001_0FFC, 32'h7777_8888, 32'h0, 1'b0, 8'd0, 1, "l1 store_last");
    xact(1'b0, 32'h1001_0FFC, 32'h0, 32'h7777_8888, 1'b0, 8'd0, 1, "l1 load_last");
    for (int i = 1; i <= 257; i++) begin
      if (i[0]) xact(1'b0, 32'h1001_0001, 32'h0, 32'h0, 1'b1,
                     (i > 255) ? 8'hFF : 8'(i), 1, $sformatf("sat%0d", i));
      else      xact(1'b1, 32'h2000_0000, 32'hFFFF_0000, 32'h0, 1'b1,
                     (i > 255) ? 8'hFF : 8'(i), 1, $sformatf("sat%0d", i));
    end
    xact(1'b0, 32'h1001_0FFC, 32'h0, 32'h7777_8888, 1'b0, 8'hFF, 1, "l1 load_after_err");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
